instr_sequencer: RTL and testbench

Program sequencer for the 8-bit CPU core. It fetches 16-bit instructions from an instruction memory over a request/valid handshake and decodes the opcode. Each datapath instruction is presented to the CPU's `instr` input for a fixed issue window. Jump and halt are resolved internally. It sits between the instruction memory and `cpu`, replacing hand-driven instruction sequences.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_sequencer_if.sv | 23 ++
 rtl/instr_classify.sv | 26 ++
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_instr_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, instruction field positions and sequencer state encoding
package cpu_pkg;

   localparam logic [3:0] OP_LDI  = 4'h0;
   localparam logic [3:0] OP_ST   = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ADDI = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int REG_MSB = 11;
   localparam int REG_LSB = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_HALTED,
      S_STEP_WAIT
   } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - instruction memory request/valid fetch bus
interface instr_sequencer_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [15:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_valid,
      output imem_rdata
   );
endinterface

// File: rtl/instr_classify.sv
// rtl/instr_classify.sv - combinational opcode classifier
module instr_classify
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_datapath,
   output logic       is_jump,
   output logic       is_halt,
   output logic       is_illegal
);

   // Exactly one class flag is high for every opcode value.
   always_comb begin
      is_datapath = 1'b0;
      is_jump     = 1'b0;
      is_halt     = 1'b0;
      is_illegal  = 1'b0;
      case (opcode)
         OP_LDI, OP_ST, OP_LD, OP_ADDI: is_datapath = 1'b1;
         OP_JMP:                        is_jump     = 1'b1;
         OP_HALT:                       is_halt     = 1'b1;
         default:                       is_illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/issue program sequencer; optional single-step via INSTR_SEQ_STEP_EN
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_W         = 8,
   parameter int ISSUE_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
`ifdef INSTR_SEQ_STEP_EN
   input  logic            step,
`endif
   instr_sequencer_if.master imem,
   output logic [15:0]     instr,
   output logic            instr_valid,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [15:0]     retired
);

   localparam int CNT_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISSUE_CYCLES - 1);

   seq_state_e      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [15:0]     retired_q, retired_d;
   logic            err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]     instr_q, instr_d;
   logic            instr_valid_q, instr_valid_d;

   logic is_datapath, is_jump, is_halt, is_illegal;

   instr_classify u_classify (
      .opcode      (ir_q[OPC_MSB:OPC_LSB]),
      .is_datapath (is_datapath),
      .is_jump     (is_jump),
      .is_halt     (is_halt),
      .is_illegal  (is_illegal)
   );

   // State register and architectural state; reset clears everything without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         ir_q          <= '0;
         retired_q     <= '0;
         err_q         <= 1'b0;
         cnt_q         <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         retired_q     <= retired_d;
         err_q         <= err_d;
         cnt_q         <= cnt_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // Next-state logic; the CPU-facing instruction is registered off the next state.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               retired_d = '0;
               err_d     = 1'b0;
            end
         end
         S_FETCH: begin
            if (imem.imem_valid) begin
               ir_d    = imem.imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_datapath) begin
               state_d = S_ISSUE;
               cnt_d   = '0;
            end else if (is_jump) begin
               pc_d    = ir_q[PC_W-1:0];
               state_d = S_FETCH;
            end else begin
               err_d   = err_q | is_illegal;
               state_d = S_HALTED;
            end
         end
         S_ISSUE: begin
            if (cnt_q == CNT_LAST) begin
               pc_d = pc_q + 1'b1;
               if (retired_q != 16'hFFFF) begin
                  retired_d = retired_q + 16'd1;
               end
`ifdef INSTR_SEQ_STEP_EN
               state_d = S_STEP_WAIT;
`else
               state_d = S_FETCH;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef INSTR_SEQ_STEP_EN
         S_STEP_WAIT: begin
            if (step) begin
               state_d = S_FETCH;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
      instr_valid_d = (state_d == S_ISSUE);
      instr_d       = instr_valid_d ? ir_q : 16'h0000;
   end

   // Output decode from registered state.
   always_comb begin
      imem.imem_req  = (state_q == S_FETCH);
      imem.imem_addr = (state_q == S_FETCH) ? pc_q : '0;
      busy           = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_ISSUE) || (state_q == S_STEP_WAIT);
      done           = (state_q == S_HALTED);
      instr          = instr_q;
      instr_valid    = instr_valid_q;
      pc             = pc_q;
      err            = err_q;
      retired        = retired_q;
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer; step test under INSTR_SEQ_STEP_EN
`timescale 1ns/1ps
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
`ifdef INSTR_SEQ_STEP_EN
   logic        step;
`endif
   logic [15:0] instr;
   logic        instr_valid;
   logic [7:0]  pc;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] retired;

   int checks   = 0;
   int failures = 0;

   logic [15:0] mem [0:255];
   int          stall_n = 0;
   int          wait_cnt = 0;
   logic [15:0] trace [$];
   int          bad_zero = 0;

   instr_sequencer_if #(.PC_W(8)) mif ();

   instr_sequencer #(.PC_W(8), .ISSUE_CYCLES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
`ifdef INSTR_SEQ_STEP_EN
      .step        (step),
`endif
      .imem        (mif),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   // Instruction memory with a programmable per-fetch stall.
   always_comb begin
      mif.imem_valid = mif.imem_req && (wait_cnt >= stall_n);
      mif.imem_rdata = mem[mif.imem_addr];
   end

   always @(posedge clk) begin
      if (reset || !mif.imem_req || mif.imem_valid) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   // Record issued words; instr must read zero outside the issue window.
   always @(negedge clk) begin
      if (instr_valid) trace.push_back(instr);
      else if (instr !== 16'h0000) bad_zero <= bad_zero + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
   endtask

   task automatic run_to_done(input int budget, output int n);
      trace.delete();
      bad_zero = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic check_trace(input string tag, input logic [15:0] exp [$]);
      check({tag, "_len"}, trace.size(), exp.size());
      for (int i = 0; i < exp.size() && i < trace.size(); i++)
         check($sformatf("%s_w%0d", tag, i), trace[i], exp[i]);
   endtask

   initial begin
      int n;
      logic [15:0] exp_q [$];
      reset = 1'b1;
      start = 1'b0;
`ifdef INSTR_SEQ_STEP_EN
      step = 1'b0;
`endif
      clear_mem();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      check("rst_pc", pc, 0);
      check("rst_retired", retired, 0);
      check("rst_err", err, 0);
      check("rst_req", mif.imem_req, 0);
      check("rst_addr", mif.imem_addr, 0);
      check("rst_instr", instr, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // Basic program, zero-wait memory.
      clear_mem();
      mem[0] = 16'h0004; mem[1] = 16'h1002; mem[2] = 16'h2102; mem[3] = 16'h3107; mem[4] = 16'hF000;
      run_to_done(100, n);
      check("basic_done", done, 1);
      check("basic_cycles", n, 18);
      exp_q = '{16'h0004, 16'h0004, 16'h1002, 16'h1002, 16'h2102, 16'h2102, 16'h3107, 16'h3107};
      check_trace("basic", exp_q);
      check("basic_zero", bad_zero, 0);
      check("basic_retired", retired, 4);
      check("basic_pc", pc, 4);
      check("basic_err", err, 0);
      check("basic_busy", busy, 0);

      // Jump over a gap straight to HALT.
      clear_mem();
      mem[0] = 16'hE005; mem[1] = 16'h0001; mem[5] = 16'hF000;
      run_to_done(100, n);
      check("jmp_done", done, 1);
      check("jmp_cycles", n, 4);
      check("jmp_issued", trace.size(), 0);
      check("jmp_pc", pc, 5);
      check("jmp_retired", retired, 0);

      // Illegal opcode after one datapath instruction.
      clear_mem();
      mem[0] = 16'h0009; mem[1] = 16'h7000;
      run_to_done(100, n);
      check("ill_done", done, 1);
      check("ill_cycles", n, 6);
      exp_q = '{16'h0009, 16'h0009};
      check_trace("ill", exp_q);
      check("ill_err", err, 1);
      check("ill_retired", retired, 1);
      check("ill_pc", pc, 1);
      clear_mem();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ill_err_clear", err, 0);
      check("ill_restart_busy", busy, 1);
      n = 0;
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      check("ill_restart_done", done, 1);

      // Fetch stalls of three cycles per fetch.
      clear_mem();
      stall_n = 3;
      mem[0] = 16'h0011; mem[1] = 16'h3122; mem[2] = 16'hF000;
      run_to_done(100, n);
      check("stall_done", done, 1);
      check("stall_cycles", n, 19);
      exp_q = '{16'h0011, 16'h0011, 16'h3122, 16'h3122};
      check_trace("stall", exp_q);
      check("stall_zero", bad_zero, 0);
      stall_n = 0;

      // Asynchronous reset in the second issue cycle of the second instruction.
      clear_mem();
      mem[0] = 16'h0004; mem[1] = 16'h1002; mem[2] = 16'hF000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(instr_valid && instr == 16'h1002) && n < 50) begin @(posedge clk); #1; n++; end
      check("rmid_reach", instr, 16'h1002);
      @(posedge clk); #1;
      check("rmid_pre_valid", instr_valid, 1);
      check("rmid_pre_pc", pc, 1);
      #2 reset = 1'b1;
      #1;
      check("rmid_valid", instr_valid, 0);
      check("rmid_req", mif.imem_req, 0);
      check("rmid_instr", instr, 0);
      check("rmid_pc", pc, 0);
      check("rmid_retired", retired, 0);
      check("rmid_busy", busy, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check("rmid_idle_busy", busy, 0);

`ifdef INSTR_SEQ_STEP_EN
      // Single step: each instruction waits for a step pulse before the next fetch.
      clear_mem();
      mem[0] = 16'h0001; mem[1] = 16'h1001; mem[2] = 16'h2001; mem[3] = 16'hF000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         n = 0;
         while (retired != 16'(k) && n < 50) begin @(posedge clk); #1; n++; end
         repeat (4) @(posedge clk);
         #1;
         check($sformatf("step%0d_retired", k), retired, k);
         check($sformatf("step%0d_valid", k), instr_valid, 0);
         check($sformatf("step%0d_req", k), mif.imem_req, 0);
         check($sformatf("step%0d_busy", k), busy, 1);
         step = 1'b1;
         @(posedge clk); #1;
         step = 1'b0;
      end
      n = 0;
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      check("step_done", done, 1);
      check("step_retired", retired, 3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
